conv_window_rd_seq: RTL and testbench

//  Clocked read sequencer directly upstream of the ifmap memory. It produces the read-address

---
 rtl/conv_window_rd_seq_pkg.sv | 24 ++
 rtl/conv_window_rd_seq_if.sv | 38 +++
 rtl/conv_window_rd_seq_fifo.sv | 57 +++++
 rtl/conv_window_rd_seq.sv | 160 ++++++++++++++++
 tb/tb_conv_window_rd_seq.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_window_rd_seq_pkg.sv
// Shared FSM state type and window address helper
// for the convolution window read sequencer.
package cnn_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_e;

   // Address of element (i,j) of window (r,c); caller truncates.
   function automatic logic [31:0] win_addr(
      input logic [31:0] base,
      input logic [31:0] r,
      input logic [31:0] c,
      input logic [31:0] i,
      input logic [31:0] j,
      input logic [31:0] img = 32'd5
   );
      return base + (r + i) * img + c + j;
   endfunction

endpackage

// File: rtl/conv_window_rd_seq_if.sv
// Memory address/data channels and the forwarded
// output channel of the window read sequencer.
interface conv_window_rd_seq_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          addr_valid;
   logic          addr_ready;
   logic [AW-1:0] addr;
   logic          rdata_valid;
   logic          rdata_ready;
   logic [DW-1:0] rdata;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic [7:0]    out_win_idx;

   modport master (
      output addr_valid, addr,
      input  addr_ready,
      input  rdata_valid, rdata,
      output rdata_ready,
      output out_valid, out_data,
      output out_last, out_win_idx,
      input  out_ready
   );

   modport slave (
      input  addr_valid, addr,
      output addr_ready,
      output rdata_valid, rdata,
      input  rdata_ready,
      input  out_valid, out_data,
      input  out_last, out_win_idx,
      output out_ready
   );
endinterface

// File: rtl/conv_window_rd_seq_fifo.sv
// Small synchronous FIFO holding returned read data
// until the downstream stage accepts it.
module sync_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [DW-1:0]              i_data,
   input  logic                       i_pop,
   output logic [DW-1:0]              o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [DW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   function automatic logic [PW-1:0] nxt(
      input logic [PW-1:0] p
   );
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= nxt(r_wptr);
         if (w_pop)  r_rptr <= nxt(r_rptr);
         r_count <= r_count + CW'(w_push)
                            - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end

endmodule

// File: rtl/conv_window_rd_seq.sv
// Issues KxK stride-1 window reads over an IMGxIMG ifmap and
// forwards the returned words tagged with window index/last.
module conv_window_rd_seq
   import cnn_seq_pkg::*;
#(
   parameter int IMG   = 5,
   parameter int K     = 3,
   parameter int AW    = 8,
   parameter int DW    = 8,
   parameter int OUTST = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   input  logic [AW-1:0]        i_base_addr,
   output logic                 o_busy,
   output logic                 o_done,
   conv_window_rd_seq_if.master bus
);
   localparam int OUT = IMG - K + 1;
   localparam int KK  = K * K;
   localparam int NW  = OUT * OUT;
   localparam int CW  = $clog2(IMG+1);
   localparam int EW  = $clog2(KK+1);
   localparam int OW  = $clog2(OUTST+1);

   state_e        r_state;
   state_e        w_next;
   logic [AW-1:0] r_base;
   logic [CW-1:0] r_r;
   logic [CW-1:0] r_c;
   logic [CW-1:0] r_i;
   logic [CW-1:0] r_j;
   logic [EW-1:0] r_elem;
   logic [7:0]    r_win;
   logic [OW-1:0] r_outst;

   logic          w_afire;
   logic          w_rfire;
   logic          w_ofire;
   logic          w_last_addr;
   logic          w_start_acc;
   logic          w_full;
   logic          w_empty;
   logic [DW-1:0] w_head;
   logic [OW-1:0] w_cnt;

   assign w_start_acc = i_start & (r_state == ST_IDLE);
   assign w_afire = bus.addr_valid & bus.addr_ready;
   assign w_rfire = bus.rdata_valid & bus.rdata_ready;
   assign w_ofire = bus.out_valid & bus.out_ready;
   assign w_last_addr = (r_r == CW'(OUT-1)) &&
                        (r_c == CW'(OUT-1)) &&
                        (r_i == CW'(K-1)) &&
                        (r_j == CW'(K-1));

   // Credit covers both in-flight reads and FIFO entries.
   assign bus.addr_valid = (r_state == ST_RUN) &&
                           (r_outst < OW'(OUTST));
   assign bus.addr = AW'(win_addr(32'(r_base),
                                  32'(r_r), 32'(r_c),
                                  32'(r_i), 32'(r_j),
                                  32'(IMG)));
   assign bus.rdata_ready = o_busy & ~w_full;
   assign bus.out_valid   = ~w_empty;
   assign bus.out_data    = w_empty ? '0 : w_head;
   assign bus.out_last    = ~w_empty &&
                            (r_elem == EW'(KK-1));
   assign bus.out_win_idx = r_win;

   always_comb begin
      w_next = r_state;
      o_busy = 1'b0;
      o_done = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (i_start) w_next = ST_RUN;
         end
         ST_RUN: begin
            o_busy = 1'b1;
            if (w_afire && w_last_addr)
               w_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            o_busy = 1'b1;
            if (w_cnt == '0 && r_outst == '0)
               w_next = ST_DONE;
         end
         ST_DONE: begin
            o_busy = 1'b1;
            o_done = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_base  <= '0;
         r_r     <= '0;
         r_c     <= '0;
         r_i     <= '0;
         r_j     <= '0;
         r_elem  <= '0;
         r_win   <= '0;
         r_outst <= '0;
      end else begin
         r_state <= w_next;
         if (w_start_acc) r_base <= i_base_addr;
         if (w_afire) begin
            if (r_j != CW'(K-1)) begin
               r_j <= r_j + 1'b1;
            end else begin
               r_j <= '0;
               if (r_i != CW'(K-1)) begin
                  r_i <= r_i + 1'b1;
               end else begin
                  r_i <= '0;
                  if (r_c != CW'(OUT-1)) begin
                     r_c <= r_c + 1'b1;
                  end else begin
                     r_c <= '0;
                     r_r <= (r_r != CW'(OUT-1)) ?
                            r_r + 1'b1 : '0;
                  end
               end
            end
         end
         if (w_ofire) begin
            if (r_elem != EW'(KK-1)) begin
               r_elem <= r_elem + 1'b1;
            end else begin
               r_elem <= '0;
               r_win  <= (r_win == 8'(NW-1)) ?
                         '0 : r_win + 1'b1;
            end
         end
         r_outst <= r_outst + OW'(w_afire)
                            - OW'(w_ofire);
      end
   end

   sync_fifo #(
      .DW    (DW),
      .DEPTH (OUTST)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_rfire),
      .i_data  (bus.rdata),
      .i_pop   (w_ofire),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_cnt)
   );

endmodule

// File: tb/tb_conv_window_rd_seq.sv
// Scoreboard bench for conv_window_rd_seq: random stalls,
// latency, wrap, mid-frame reset and ignored starts.
module tb_conv_window_rd_seq;
   localparam int IMG   = 5;
   localparam int K     = 3;
   localparam int AW    = 8;
   localparam int DW    = 8;
   localparam int OUTST = 4;
   localparam int OUT   = IMG - K + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic          busy;
   logic          done;

   conv_window_rd_seq_if #(.AW(AW), .DW(DW)) bus();

   conv_window_rd_seq #(
      .IMG(IMG), .K(K), .AW(AW), .DW(DW), .OUTST(OUTST)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (start),
      .i_base_addr (base_addr),
      .o_busy      (busy),
      .o_done      (done),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int lat = 1;
   int ar_pct = 100;
   int or_pct = 100;
   int n_done = 0;
   int n_frames = 0;
   int n_afire = 0;
   int outst = 0;

   logic [7:0] exp_addr[$];
   logic [7:0] exp_d[$];
   logic       exp_l[$];
   int         exp_w[$];
   int         mem_t[$];
   logic [7:0] mem_d[$];

   logic       pa_stall = 1'b0;
   logic [7:0] pa = '0;
   logic       po_stall = 1'b0;
   logic [7:0] pd = '0;
   logic       pl = 1'b0;
   logic [7:0] pw = '0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Reference: the frame's full read order from the window rules.
   task automatic push_frame(input logic [7:0] b);
      logic [7:0] a;
      for (int r = 0; r < OUT; r++)
         for (int c = 0; c < OUT; c++)
            for (int i = 0; i < K; i++)
               for (int j = 0; j < K; j++) begin
                  a = 8'((int'(b) + (r + i) * IMG + c + j) % 256);
                  exp_addr.push_back(a);
                  exp_d.push_back(a);
                  exp_l.push_back(i == K - 1 && j == K - 1);
                  exp_w.push_back(r * OUT + c);
               end
   endtask

   task automatic rst_checks();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr_valid", bus.addr_valid, 0);
      chk("rst_addr", bus.addr, 0);
      chk("rst_rdata_ready", bus.rdata_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_win_idx", bus.out_win_idx, 0);
   endtask

   // Memory model: returns the address as data after lat cycles.
   initial begin
      bus.addr_ready  = 1'b0;
      bus.rdata_valid = 1'b0;
      bus.rdata       = '0;
      bus.out_ready   = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         bus.addr_ready = ($urandom_range(99) < ar_pct);
         bus.out_ready  = ($urandom_range(99) < or_pct);
         if (mem_t.size() > 0 && mem_t[0] <= cyc) begin
            bus.rdata_valid = 1'b1;
            bus.rdata       = mem_d[0];
         end else begin
            bus.rdata_valid = !busy && ($urandom_range(3) == 0);
            bus.rdata       = 8'($urandom);
         end
         #1;
         if (rst) begin
            mem_t.delete();
            mem_d.delete();
         end else begin
            if (bus.addr_valid && bus.addr_ready) begin
               mem_t.push_back(cyc + lat);
               mem_d.push_back(bus.addr);
            end
            if (bus.rdata_valid && bus.rdata_ready &&
                mem_t.size() > 0) begin
               void'(mem_t.pop_front());
               void'(mem_d.pop_front());
            end
         end
      end
   end

   // Address channel, credit and stability monitor.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            outst    = 0;
            pa_stall = 1'b0;
            po_stall = 1'b0;
         end else begin
            if (pa_stall) begin
               chk("addr_hold_valid", bus.addr_valid, 1);
               chk("addr_hold", bus.addr, pa);
            end
            if (po_stall) begin
               chk("out_hold_valid", bus.out_valid, 1);
               chk("out_hold_data", bus.out_data, pd);
               chk("out_hold_last", bus.out_last, pl);
               chk("out_hold_win", bus.out_win_idx, pw);
            end
            if (outst >= OUTST)
               chk("credit_block", bus.addr_valid, 0);
            if (bus.addr_valid && bus.addr_ready) begin
               n_afire++;
               outst++;
               if (exp_addr.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL addr_extra: got %0h want none",
                           bus.addr);
               end else begin
                  chk("addr", bus.addr, exp_addr.pop_front());
               end
            end
            if (bus.out_valid && bus.out_ready) outst--;
            if (done) n_done++;
            pa_stall = bus.addr_valid && !bus.addr_ready;
            pa       = bus.addr;
            po_stall = bus.out_valid && !bus.out_ready;
            pd       = bus.out_data;
            pl       = bus.out_last;
            pw       = bus.out_win_idx;
         end
      end
   end

   // Output scoreboard monitor.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_d.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL out_extra: got %0h want none",
                        bus.out_data);
            end else begin
               chk("out_data", bus.out_data, exp_d.pop_front());
               chk("out_last", bus.out_last, exp_l.pop_front());
               chk("out_win_idx", bus.out_win_idx,
                   exp_w.pop_front());
            end
         end
      end
   end

   task automatic run_frame(input logic [7:0] b, input int l,
                            input int apct, input int opct,
                            input int abort_at, input bit poke);
      bit got;
      lat    = l;
      ar_pct = apct;
      or_pct = opct;
      chk("idle_before_start", busy, 0);
      start     = 1'b1;
      base_addr = b;
      push_frame(b);
      n_afire = 0;
      @(negedge clk);
      #2;
      start     = 1'b0;
      base_addr = 8'($urandom);
      chk("busy_after_start", busy, 1);
      chk("addr_valid_first", bus.addr_valid, 1);
      got = 1'b0;
      for (int t = 0; t < 3000 && !got; t++) begin
         if (abort_at > 0 && n_afire >= abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            #2;
            rst_checks();
            rst = 1'b0;
            exp_addr.delete();
            exp_d.delete();
            exp_l.delete();
            exp_w.delete();
            return;
         end
         if (poke && t == 15) begin
            start     = 1'b1;
            base_addr = 8'h77;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            got = 1'b1;
         end else begin
            @(negedge clk);
            #2;
         end
      end
      if (!got) begin
         n_cmp++;
         n_err++;
         $display("FAIL frame_timeout: got no done want done");
      end else begin
         n_frames++;
      end
      chk("outq_drained", exp_d.size(), 0);
      chk("addrq_drained", exp_addr.size(), 0);
      if (poke) start = 1'b1;
      @(negedge clk);
      #2;
      start = 1'b0;
      chk("done_pulse_width", done, 0);
      if (poke) chk("start_at_done_ignored", busy, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #2;
      rst_checks();
      rst = 1'b0;
      @(negedge clk);
      #2;
      run_frame(8'h10, 1, 100, 100, 0, 1'b0);
      run_frame(8'h10, 6, 100, 100, 0, 1'b0);
      run_frame(8'($urandom), 3, 50, 50, 0, 1'b0);
      run_frame(8'hF8, 2, 100, 100, 0, 1'b0);
      run_frame(8'h33, 2, 100, 100, 20, 1'b0);
      repeat (8) @(negedge clk);
      #2;
      run_frame(8'h40, 1, 100, 100, 0, 1'b0);
      run_frame(8'($urandom), 2, 70, 60, 0, 1'b1);
      run_frame(8'($urandom), 1, 100, 100, 0, 1'b0);
      for (int n = 0; n < 3; n++)
         run_frame(8'($urandom), $urandom_range(1, 5),
                   50, 50, 0, 1'b0);
      repeat (4) @(negedge clk);
      #2;
      chk("done_count", n_done, n_frames);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
